// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo alert-tune sequencer.
package piezo_pkg;

  localparam logic [20:0] NOTE_G6 = 21'd31888;
  localparam logic [20:0] NOTE_C7 = 21'd23889;
  localparam logic [20:0] NOTE_E7 = 21'd18961;
  localparam logic [20:0] NOTE_G7 = 21'd15944;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    EN_STEER = 2'd1,
    BATT_LOW = 2'd2,
    TOO_FAST = 2'd3
  } tune_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [1:0] LAST_EN_STEER = 2'd3;
  localparam logic [1:0] LAST_BATT_LOW = 2'd3;
  localparam logic [1:0] LAST_TOO_FAST = 2'd2;

endpackage

// File: rtl/piezo_note_rom.sv
// Combinational note table: (tune, idx) -> period, length in units, last-note flag.
module piezo_note_rom
  import piezo_pkg::*;
(
  input  tune_e       tune,
  input  logic [1:0]  idx,
  output logic [20:0] period,
  output logic [1:0]  len_units,
  output logic        last
);

  always_comb begin
    period    = 21'd0;
    len_units = 2'd1;
    last      = 1'b1;
    case (tune)
      TOO_FAST: begin
        last = (idx == LAST_TOO_FAST);
        case (idx)
          2'd0:    period = NOTE_G6;
          2'd1:    period = NOTE_C7;
          default: period = NOTE_E7;
        endcase
      end
      BATT_LOW: begin
        last = (idx == LAST_BATT_LOW);
        case (idx)
          2'd0:    period = NOTE_G7;
          2'd1:    period = NOTE_E7;
          2'd2:    period = NOTE_C7;
          default: period = NOTE_G6;
        endcase
      end
      EN_STEER: begin
        last = (idx == LAST_EN_STEER);
        case (idx)
          2'd0:    period = NOTE_G6;
          2'd1:    period = NOTE_C7;
          2'd2:    period = NOTE_E7;
          default: begin
            period    = NOTE_G7;
            len_units = 2'd2;
          end
        endcase
      end
      default: len_units = 2'd0;
    endcase
  end

endmodule

// File: rtl/piezo_tune_seq.sv
// Alert-tune sequencer: arbitrates alert requests and drives piezo PWM period/duty.
module piezo_tune_seq
  import piezo_pkg::*;
#(
  parameter int DUR_UNIT = 4194304,
  parameter int GAP_CYC  = 262144
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        too_fast,
  input  logic        batt_low,
  input  logic        en_steer,
  output logic [20:0] max_cnt,
  output logic [19:0] duty,
  output logic        busy,
  output logic [1:0]  tune
);

  localparam int DUR_W = $clog2(2 * DUR_UNIT + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  state_e            state_q, state_d;
  tune_e             tune_q, tune_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        len_q, len_d;
  logic              last_q, last_d;
  logic [DUR_W-1:0]  dcnt_q, dcnt_d;
  logic [GAP_W-1:0]  gcnt_q, gcnt_d;
  logic              en_prev_q, en_prev_d;
  logic              en_pend_q, en_pend_d;
  logic [20:0]       max_cnt_q, max_cnt_d;
  logic [19:0]       duty_q, duty_d;

  logic              load, en_clr, en_rise, d_term, g_term;
  logic [DUR_W-1:0]  dur_lim;
  logic [20:0]       nxt_period;
  logic [1:0]        nxt_len;
  logic              nxt_last;

  // Looks up the note about to be loaded so period/len/last register together.
  piezo_note_rom u_rom (
    .tune      (tune_d),
    .idx       (idx_d),
    .period    (nxt_period),
    .len_units (nxt_len),
    .last      (nxt_last)
  );

  assign en_rise = en_steer & ~en_prev_q;
  assign dur_lim = DUR_W'(len_q) * DUR_W'(DUR_UNIT);
  assign d_term  = (dcnt_q == dur_lim - DUR_W'(1));
  assign g_term  = (gcnt_q == GAP_W'(GAP_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tune_q    <= NONE;
      idx_q     <= 2'd0;
      len_q     <= 2'd0;
      last_q    <= 1'b0;
      dcnt_q    <= '0;
      gcnt_q    <= '0;
      en_prev_q <= 1'b0;
      en_pend_q <= 1'b0;
      max_cnt_q <= 21'd0;
      duty_q    <= 20'd0;
    end else begin
      state_q   <= state_d;
      tune_q    <= tune_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      last_q    <= last_d;
      dcnt_q    <= dcnt_d;
      gcnt_q    <= gcnt_d;
      en_prev_q <= en_prev_d;
      en_pend_q <= en_pend_d;
      max_cnt_q <= max_cnt_d;
      duty_q    <= duty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tune_d  = tune_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    gcnt_d  = gcnt_q;
    load    = 1'b0;
    en_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (too_fast)       tune_d = TOO_FAST;
        else if (batt_low)  tune_d = BATT_LOW;
        else if (en_pend_q) begin
          tune_d = EN_STEER;
          en_clr = 1'b1;
        end
        if (too_fast || batt_low || en_pend_q) begin
          idx_d = 2'd0;
          load  = 1'b1;
        end
      end
      PLAY: begin
        if (d_term) begin
          state_d = GAP;
          gcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DUR_W'(1);
        end
      end
      GAP: begin
        if (!g_term) begin
          gcnt_d = gcnt_q + GAP_W'(1);
        end else if (too_fast && tune_q != TOO_FAST) begin
          en_clr = (tune_q == EN_STEER);
          tune_d = TOO_FAST;
          idx_d  = 2'd0;
          load   = 1'b1;
        end else if (!last_q) begin
          idx_d = idx_q + 2'd1;
          load  = 1'b1;
        end else if (tune_q == TOO_FAST && too_fast) begin
          idx_d = 2'd0;
          load  = 1'b1;
        end else begin
          state_d = IDLE;
          tune_d  = NONE;
          idx_d   = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = PLAY;
      dcnt_d  = '0;
    end
    len_d     = load ? nxt_len : len_q;
    last_d    = load ? nxt_last : last_q;
    en_prev_d = en_steer;
    en_pend_d = en_rise | (en_pend_q & ~en_clr);
  end

  always_comb begin
    max_cnt_d = max_cnt_q;
    duty_d    = duty_q;
    if (load) begin
      max_cnt_d = nxt_period;
      duty_d    = nxt_period[20:1];
    end else if (state_q == PLAY && d_term) begin
      duty_d = 20'd0;
    end
  end

  assign max_cnt = max_cnt_q;
  assign duty    = duty_q;
  assign busy    = (state_q != IDLE);
  assign tune    = tune_q;

endmodule

// File: tb/tb_piezo_tune_seq.sv
// Randomized bench for piezo_tune_seq against a note-schedule reference model.
module tb_piezo_tune_seq;

  localparam int DUR = 16;
  localparam int GAPC = 4;

  logic        clk = 1'b0;
  logic        rst_n, too_fast, batt_low, en_steer;
  logic [20:0] max_cnt;
  logic [19:0] duty;
  logic        busy;
  logic [1:0]  tune;

  int total = 0;
  int bad = 0;

  // Reference model: tune tables plus a remaining-cycles countdown per phase.
  int per_tab [4][4] = '{'{0, 0, 0, 0}, '{31888, 23889, 18961, 15944},
                         '{15944, 18961, 23889, 31888}, '{31888, 23889, 18961, 0}};
  int len_tab [4][4] = '{'{0, 0, 0, 0}, '{1, 1, 1, 2}, '{1, 1, 1, 1}, '{1, 1, 1, 0}};
  int cnt_tab [4] = '{0, 4, 4, 3};
  int m_phase, m_tune, m_idx, m_left, m_max, m_duty;
  bit m_pend, m_prev;

  piezo_tune_seq #(.DUR_UNIT(DUR), .GAP_CYC(GAPC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .too_fast (too_fast),
    .batt_low (batt_low),
    .en_steer (en_steer),
    .max_cnt  (max_cnt),
    .duty     (duty),
    .busy     (busy),
    .tune     (tune)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_tune = 0; m_idx = 0; m_left = 0;
    m_max = 0; m_duty = 0; m_pend = 0; m_prev = 0;
  endtask

  task automatic start_note(input int t, input int i);
    m_tune = t; m_idx = i;
    m_max = per_tab[t][i];
    m_duty = m_max / 2;
    m_phase = 1;
    m_left = len_tab[t][i] * DUR;
  endtask

  task automatic model_step();
    bit rise, clr;
    int w;
    rise = en_steer && !m_prev;
    clr = 0;
    case (m_phase)
      0: begin
        w = too_fast ? 3 : batt_low ? 2 : m_pend ? 1 : 0;
        if (w == 1) clr = 1;
        if (w != 0) start_note(w, 0);
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_duty = 0; m_phase = 2; m_left = GAPC;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (too_fast && m_tune != 3) begin
            if (m_tune == 1) clr = 1;
            start_note(3, 0);
          end else if (m_idx + 1 < cnt_tab[m_tune]) begin
            start_note(m_tune, m_idx + 1);
          end else if (m_tune == 3 && too_fast) begin
            start_note(3, 0);
          end else begin
            m_phase = 0; m_tune = 0;
          end
        end
      end
    endcase
    m_pend = rise || (m_pend && !clr);
    m_prev = en_steer;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("max_cnt", int'(max_cnt), m_max);
    chk("duty", int'(duty), m_duty);
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("tune", int'(tune), m_tune);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_idle(input int max_cyc);
    int quiet = 0;
    for (int i = 0; i < max_cyc && quiet < 2; i++) begin
      cycle();
      quiet = (!busy && m_phase == 0) ? quiet + 1 : 0;
    end
    if (quiet < 2) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_max"}, int'(max_cnt), 0);
    chk({tag, "_duty"}, int'(duty), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_tune"}, int'(tune), 0);
  endtask

  task automatic pulse_en();
    en_steer = 1'b1;
    cycle();
    en_steer = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int d;
    rst_n = 1'b0; too_fast = 1'b0; batt_low = 1'b0; en_steer = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(3);

    // Single en_steer pulse: full EN_STEER tune, busy for 96 cycles.
    pulse_en();
    busy_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      cycle();
      if (i == 0) begin
        chk("en_first_max", int'(max_cnt), 31888);
        chk("en_first_duty", int'(duty), 15944);
        chk("en_first_tune", int'(tune), 1);
      end
      if (busy) busy_cnt++;
    end
    chk("en_busy_cycles", busy_cnt, 96);

    // too_fast held for a random stretch, then released.
    too_fast = 1'b1;
    run($urandom_range(150, 250));
    too_fast = 1'b0;
    run_until_idle(200);

    // batt_low raised during an EN_STEER tune.
    pulse_en();
    run($urandom_range(5, 60));
    batt_low = 1'b1;
    run($urandom_range(100, 140));
    batt_low = 1'b0;
    run_until_idle(300);

    // too_fast raised during EN_STEER C7: preempts at end of that gap.
    pulse_en();
    run($urandom_range(21, 34));
    too_fast = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (tune == 2'd3 && m_tune == 3 && i < 20) chk("preempt_max", int'(max_cnt), 31888);
    end
    too_fast = 1'b0;
    run_until_idle(200);

    // All three requests in the same cycle.
    too_fast = 1'b1; batt_low = 1'b1;
    pulse_en();
    run($urandom_range(30, 60));
    too_fast = 1'b0;
    run($urandom_range(80, 120));
    batt_low = 1'b0;
    run_until_idle(400);
    run(120);

    // Random request traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) too_fast = ~too_fast;
      if ($urandom_range(0, 39) == 0) batt_low = ~batt_low;
      if ($urandom_range(0, 9) == 0) en_steer = ~en_steer;
      cycle();
    end
    too_fast = 1'b0; batt_low = 1'b0; en_steer = 1'b0;
    run_until_idle(500);

    // Asynchronous reset in the middle of a note.
    pulse_en();
    d = $urandom_range(3, 12);
    run(d);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(4);
    pulse_en();
    run_until_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
